rcc_switch_ctrl: RTL

- Control-side sequencer that drives the 2-bit RCC_CR word into the clock switching module (csm) and consumes its clk_ext_100M_ready status.
- Runs on the always-on internal clock and accepts one source-change request at a time.
- To switch to the external 100 MHz clock it enables the oscillator, waits for a synchronized and stable ready, then flips the select bit.
- To switch back to the internal clock it reverses that order. A timeout aborts the switch if the oscillator never reports ready.

---
 rtl/rcc_switch_ctrl.sv | 155 +++++++++++++++
 1 files changed

// File: rtl/rcc_switch_ctrl.sv
// rcc_switch_ctrl: sequences RCC_CR (HSE_ON, SW) into the clock switching module; optional clock security via RCC_CSS_EN
module rcc_switch_ctrl #(
  parameter int READY_TIMEOUT = 65536,
  parameter int STABLE_CYCLES = 16,
  parameter int SETTLE_CYCLES = 8,
  parameter int SYNC_STAGES   = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       req_valid,
  input  logic       req_src,
  output logic       req_ready,
  input  logic       clk_ext_ready_async,
  output logic [1:0] rcc_cr_out,
  output logic       cur_src,
  output logic       busy,
  output logic       done,
  output logic       err_timeout,
  output logic       css_fault
);
  localparam int TW   = $clog2(READY_TIMEOUT) + 1;
  localparam int CMAX = (STABLE_CYCLES > SETTLE_CYCLES) ? STABLE_CYCLES : SETTLE_CYCLES;
  localparam int CW   = $clog2(CMAX) + 1;

  typedef enum logic [1:0] {IDLE, HSE_WAIT, HSE_STABLE, SW_SETTLE} state_t;

  state_t                 state_q, state_d;
  logic [TW-1:0]          timer_q, timer_d;
  logic [CW-1:0]          cnt_q, cnt_d;
  logic                   dir_q, dir_d;
  logic [1:0]             cr_q, cr_d;
  logic                   cur_q, cur_d;
  logic                   done_q, done_d;
  logic                   err_q, err_d;
  logic                   css_q, css_d;
  logic [SYNC_STAGES-1:0] sync_q, sync_d;
  logic                   rdy_sync;
  logic                   css_trig;

  assign rdy_sync = sync_q[SYNC_STAGES-1];

`ifdef RCC_CSS_EN
  assign css_trig = (state_q == IDLE) && cur_q && !rdy_sync;
`else
  assign css_trig = 1'b0;
`endif

  assign req_ready   = (state_q == IDLE) && !css_trig;
  assign busy        = (state_q != IDLE);
  assign rcc_cr_out  = cr_q;
  assign cur_src     = cur_q;
  assign done        = done_q;
  assign err_timeout = err_q;
  assign css_fault   = css_q;

  // next-state and output-register computation for the switch sequencer
  always_comb begin
    sync_d  = {sync_q[SYNC_STAGES-2:0], clk_ext_ready_async};
    state_d = state_q;
    timer_d = timer_q;
    cnt_d   = cnt_q;
    dir_d   = dir_q;
    cr_d    = cr_q;
    cur_d   = cur_q;
    done_d  = 1'b0;
    err_d   = err_q;
    css_d   = css_q;
    case (state_q)
      IDLE: begin
        if (css_trig) begin
          cr_d   = 2'b00;
          cur_d  = 1'b0;
          css_d  = 1'b1;
          done_d = 1'b1;
        end else if (req_valid) begin
          err_d = 1'b0;
          css_d = 1'b0;
          if (req_src == cur_q) begin
            done_d = 1'b1;
          end else if (req_src) begin
            cr_d    = 2'b10;
            timer_d = '0;
            state_d = HSE_WAIT;
          end else begin
            cr_d[0] = 1'b0;
            cnt_d   = '0;
            dir_d   = 1'b0;
            state_d = SW_SETTLE;
          end
        end
      end
      HSE_WAIT: begin
        timer_d = timer_q + 1'b1;
        if (rdy_sync) begin
          cnt_d   = '0;
          state_d = HSE_STABLE;
        end else if (timer_q >= TW'(READY_TIMEOUT - 1)) begin
          cr_d    = 2'b00;
          err_d   = 1'b1;
          done_d  = 1'b1;
          state_d = IDLE;
        end
      end
      HSE_STABLE: begin
        if (!rdy_sync) begin
          state_d = HSE_WAIT;
        end else if (cnt_q == CW'(STABLE_CYCLES - 1)) begin
          cr_d    = 2'b11;
          cnt_d   = '0;
          dir_d   = 1'b1;
          state_d = SW_SETTLE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      SW_SETTLE: begin
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == CW'(SETTLE_CYCLES - 1)) begin
          cur_d   = dir_q;
          cr_d    = dir_q ? cr_q : 2'b00;
          done_d  = 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // state, counters, synchronizer and output registers with async reset
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      timer_q <= '0;
      cnt_q   <= '0;
      dir_q   <= 1'b0;
      cr_q    <= 2'b00;
      cur_q   <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
      css_q   <= 1'b0;
      sync_q  <= '0;
    end else begin
      state_q <= state_d;
      timer_q <= timer_d;
      cnt_q   <= cnt_d;
      dir_q   <= dir_d;
      cr_q    <= cr_d;
      cur_q   <= cur_d;
      done_q  <= done_d;
      err_q   <= err_d;
      css_q   <= css_d;
      sync_q  <= sync_d;
    end
  end
endmodule
